// File: rtl/acc_bank.sv
// Bank of DEPTH accumulators with load/add/clear, per-entry zero/overflow flags,
// and a one-deep registered valid/ready dump buffer towards the register file.
module acc_bank #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2,
    parameter bit SAT    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        op,
    input  logic [1:0]        src_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  in_imm,
    input  logic [WIDTH-1:0]  in_reg,
    input  logic [WIDTH-1:0]  in_alu,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  out_alu,
    input  logic              dump_req,
    input  logic [ADDR_W-1:0] dump_addr,
    output logic              dump_busy,
    output logic [WIDTH-1:0]  out_reg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              flag_zero,
    output logic              flag_ovf,
    output logic              dump_state
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        DUMP_EMPTY = 1'b0,
        DUMP_FULL  = 1'b1
    } dump_state_t;

    logic [WIDTH-1:0] entry [DEPTH];
    logic [DEPTH-1:0] ovf;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] add_result;

    dump_state_t state_q, state_d;
    logic        load_out;

    always_comb begin
        opnd = '0;
        case (src_sel)
            2'b00:   opnd = in_imm;
            2'b01:   opnd = in_reg;
            2'b10:   opnd = in_alu;
            default: opnd = '0;
        endcase
    end

    always_comb begin
        sum        = {1'b0, entry[wr_addr]} + {1'b0, opnd};
        carry      = sum[WIDTH];
        add_result = sum[WIDTH-1:0];
        if (SAT && carry) begin
            add_result = '1;
        end
    end

    // Only entry wr_addr is touched; its overflow bit is sticky across ADDs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= '0;
            end
            ovf <= '0;
        end else begin
            case (op)
                OP_LOAD: begin
                    entry[wr_addr] <= opnd;
                    ovf[wr_addr]   <= 1'b0;
                end
                OP_ADD: begin
                    entry[wr_addr] <= add_result;
                    ovf[wr_addr]   <= ovf[wr_addr] | carry;
                end
                OP_CLEAR: begin
                    entry[wr_addr] <= '0;
                    ovf[wr_addr]   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_alu   = entry[rd_addr];
    assign flag_zero = (entry[rd_addr] == '0);
    assign flag_ovf  = ovf[rd_addr];

    // Handshake: out_reg is offered while out_valid=1 and must not change until a
    // rising edge where out_valid && out_ready; that edge may reload it from dump_req.
    always_comb begin
        state_d  = state_q;
        load_out = 1'b0;
        case (state_q)
            DUMP_EMPTY: begin
                if (dump_req) begin
                    load_out = 1'b1;
                    state_d  = DUMP_FULL;
                end
            end
            DUMP_FULL: begin
                if (out_ready) begin
                    if (dump_req) begin
                        load_out = 1'b1;
                    end else begin
                        state_d = DUMP_EMPTY;
                    end
                end
            end
            default: state_d = DUMP_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DUMP_EMPTY;
            out_reg <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_reg <= entry[dump_addr];
            end
        end
    end

    assign out_valid  = (state_q == DUMP_FULL);
    assign dump_busy  = (state_q == DUMP_FULL) && !out_ready;
    assign dump_state = state_q;

endmodule

// File: tb/tb_acc_bank.sv
// Bench for acc_bank: a wrapping (SAT=0) and a saturating (SAT=1) instance share
// stimulus; a behavioural model is compared every cycle, plus literal spot checks.
module tb_acc_bank;

    localparam int W     = 8;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int MAXV  = 255;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [1:0]    src_sel = 2'b00;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  in_imm = '0;
    logic [W-1:0]  in_reg = '0;
    logic [W-1:0]  in_alu = '0;
    logic [AW-1:0] rd_addr = '0;
    logic          dump_req = 1'b0;
    logic [AW-1:0] dump_addr = '0;
    logic          out_ready = 1'b0;

    logic [W-1:0]  alu_o [2];
    logic [W-1:0]  reg_o [2];
    logic          busy_o [2];
    logic          valid_o [2];
    logic          zero_o [2];
    logic          ovf_o [2];
    logic          st_o [2];

    int n_checks = 0;
    int n_errors = 0;
    bit check_en = 1'b0;

    // Behavioural model, index [instance][entry]; instance 1 saturates.
    int m_entry [2][DEPTH];
    bit m_ovf   [2][DEPTH];
    bit m_full  [2];
    int m_out   [2];

    always #5 clk = ~clk;

    acc_bank #(.WIDTH(W), .ADDR_W(AW), .SAT(1'b0)) dut_wrap (
        .clk(clk), .reset(reset), .op(op), .src_sel(src_sel), .wr_addr(wr_addr),
        .in_imm(in_imm), .in_reg(in_reg), .in_alu(in_alu), .rd_addr(rd_addr),
        .out_alu(alu_o[0]), .dump_req(dump_req), .dump_addr(dump_addr),
        .dump_busy(busy_o[0]), .out_reg(reg_o[0]), .out_valid(valid_o[0]),
        .out_ready(out_ready), .flag_zero(zero_o[0]), .flag_ovf(ovf_o[0]),
        .dump_state(st_o[0])
    );

    acc_bank #(.WIDTH(W), .ADDR_W(AW), .SAT(1'b1)) dut_sat (
        .clk(clk), .reset(reset), .op(op), .src_sel(src_sel), .wr_addr(wr_addr),
        .in_imm(in_imm), .in_reg(in_reg), .in_alu(in_alu), .rd_addr(rd_addr),
        .out_alu(alu_o[1]), .dump_req(dump_req), .dump_addr(dump_addr),
        .dump_busy(busy_o[1]), .out_reg(reg_o[1]), .out_valid(valid_o[1]),
        .out_ready(out_ready), .flag_zero(zero_o[1]), .flag_ovf(ovf_o[1]),
        .dump_state(st_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_entry[k][i] = 0;
                m_ovf[k][i]   = 1'b0;
            end
            m_full[k] = 1'b0;
            m_out[k]  = 0;
        end
    endtask

    task automatic model_edge();
        int opnd;
        int s;
        int pre [DEPTH];
        case (src_sel)
            2'd0:    opnd = int'(in_imm);
            2'd1:    opnd = int'(in_reg);
            2'd2:    opnd = int'(in_alu);
            default: opnd = 0;
        endcase
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) pre[i] = m_entry[k][i];
            if (op == 2'd1) begin
                m_entry[k][wr_addr] = opnd;
                m_ovf[k][wr_addr]   = 1'b0;
            end else if (op == 2'd2) begin
                s = pre[wr_addr] + opnd;
                if (s > MAXV) begin
                    m_ovf[k][wr_addr]   = 1'b1;
                    m_entry[k][wr_addr] = (k == 1) ? MAXV : s - (MAXV + 1);
                end else begin
                    m_entry[k][wr_addr] = s;
                end
            end else if (op == 2'd3) begin
                m_entry[k][wr_addr] = 0;
                m_ovf[k][wr_addr]   = 1'b0;
            end
            // The buffer can take a new word when empty or when its word leaves this edge.
            if (!m_full[k] || out_ready) begin
                if (dump_req) begin
                    m_out[k]  = pre[dump_addr];
                    m_full[k] = 1'b1;
                end else begin
                    m_full[k] = 1'b0;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) model_edge();
        #1;
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("sat%0d_out_alu", k), 32'(alu_o[k]), 32'(m_entry[k][rd_addr]));
                check($sformatf("sat%0d_flag_zero", k), 32'(zero_o[k]), 32'(m_entry[k][rd_addr] == 0));
                check($sformatf("sat%0d_flag_ovf", k), 32'(ovf_o[k]), 32'(m_ovf[k][rd_addr]));
                check($sformatf("sat%0d_out_valid", k), 32'(valid_o[k]), 32'(m_full[k]));
                check($sformatf("sat%0d_dump_busy", k), 32'(busy_o[k]), 32'(m_full[k] && !out_ready));
                check($sformatf("sat%0d_out_reg", k), 32'(reg_o[k]), 32'(m_out[k]));
                check($sformatf("sat%0d_dump_state", k), 32'(st_o[k]), 32'(m_full[k]));
            end
        end
    end

    task automatic set_op(input logic [1:0] o, input logic [1:0] s, input logic [AW-1:0] a);
        op = o;
        src_sel = s;
        wr_addr = a;
    endtask

    initial begin
        model_reset();
        #12;
        check("rst_out_valid", 32'(valid_o[0]), 32'd0);
        check("rst_flag_zero", 32'(zero_o[1]), 32'd1);
        check("rst_out_reg", 32'(reg_o[0]), 32'd0);
        reset = 1'b1;
        check_en = 1'b1;

        // LOAD from each source; read-during-write shows the old value first
        set_op(2'd1, 2'd0, 2'd2); in_imm = 8'h5A; rd_addr = 2'd2;
        #1 check("rdw_old_value", 32'(alu_o[0]), 32'h00);
        cycle();
        check("load_imm_e2", 32'(alu_o[0]), 32'h5A);
        set_op(2'd1, 2'd1, 2'd1); in_reg = 8'h33; in_alu = 8'h44; rd_addr = 2'd1;
        cycle();
        check("load_reg_e1", 32'(alu_o[1]), 32'h33);
        set_op(2'd1, 2'd2, 2'd1);
        cycle();
        check("load_alu_e1", 32'(alu_o[0]), 32'h44);

        // overflow: wrap versus saturate, then zero operand and reload
        set_op(2'd1, 2'd0, 2'd0); in_imm = 8'hF0; rd_addr = 2'd0;
        cycle();
        set_op(2'd2, 2'd2, 2'd0); in_alu = 8'h20;
        cycle();
        check("wrap_add", 32'(alu_o[0]), 32'h10);
        check("wrap_ovf", 32'(ovf_o[0]), 32'd1);
        check("sat_add", 32'(alu_o[1]), 32'hFF);
        check("sat_ovf", 32'(ovf_o[1]), 32'd1);
        set_op(2'd2, 2'd3, 2'd0); in_imm = 8'h77; in_reg = 8'h77; in_alu = 8'h77;
        cycle();
        check("sat_add_zero", 32'(alu_o[1]), 32'hFF);
        check("wrap_add_zero", 32'(alu_o[0]), 32'h10);
        set_op(2'd1, 2'd0, 2'd0); in_imm = 8'h05;
        cycle();
        check("load_clears_ovf", 32'(ovf_o[0]), 32'd0);
        set_op(2'd2, 2'd0, 2'd0); in_imm = 8'h0A;
        cycle();
        check("add_no_carry", 32'(alu_o[1]), 32'h0F);
        check("add_no_ovf", 32'(ovf_o[1]), 32'd0);

        // dump returns the pre-update value of a same-edge write
        set_op(2'd1, 2'd0, 2'd3); in_imm = 8'h77; rd_addr = 2'd3;
        cycle();
        in_imm = 8'h11; dump_req = 1'b1; dump_addr = 2'd3; out_ready = 1'b0;
        cycle();
        set_op(2'd0, 2'd0, 2'd0); dump_req = 1'b0;
        #1 check("dump_pre_value", 32'(reg_o[0]), 32'h77);
        check("dump_valid", 32'(valid_o[0]), 32'd1);
        check("e3_after_load", 32'(alu_o[0]), 32'h11);
        out_ready = 1'b1;
        cycle();
        check("dump_drained", 32'(valid_o[1]), 32'd0);
        out_ready = 1'b0;

        // backpressure: held word stays put, extra request dropped, then back-to-back
        dump_req = 1'b1; dump_addr = 2'd0;
        cycle();
        dump_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin dump_req = 1'b1; dump_addr = 2'd1; end
            else dump_req = 1'b0;
            cycle();
            check("bp_out_reg", 32'(reg_o[0]), 32'h0F);
            check("bp_busy", 32'(busy_o[1]), 32'd1);
        end
        out_ready = 1'b1; dump_req = 1'b1; dump_addr = 2'd1;
        #1 check("busy_drops_with_ready", 32'(busy_o[0]), 32'd0);
        cycle();
        check("b2b_out_reg", 32'(reg_o[0]), 32'h44);
        check("b2b_valid", 32'(valid_o[0]), 32'd1);
        dump_req = 1'b0;
        cycle();
        check("b2b_drained", 32'(valid_o[0]), 32'd0);

        // CLEAR an entry carrying overflow; neighbours untouched
        set_op(2'd1, 2'd0, 2'd2); in_imm = 8'hFF; rd_addr = 2'd2;
        cycle();
        set_op(2'd2, 2'd0, 2'd2); in_imm = 8'h02;
        cycle();
        check("pre_clear_ovf", 32'(ovf_o[0]), 32'd1);
        check("pre_clear_wrap", 32'(alu_o[0]), 32'h01);
        set_op(2'd3, 2'd1, 2'd2); in_reg = 8'h99;
        cycle();
        set_op(2'd0, 2'd0, 2'd0);
        check("clear_zero", 32'(zero_o[1]), 32'd1);
        check("clear_ovf", 32'(ovf_o[1]), 32'd0);
        rd_addr = 2'd1;
        #1 check("clear_keeps_e1", 32'(alu_o[0]), 32'h44);
        rd_addr = 2'd3;
        #1 check("clear_keeps_e3", 32'(alu_o[1]), 32'h11);

        // mixed traffic against the model
        for (int i = 0; i < 60; i++) begin
            set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), AW'($urandom_range(0, 3)));
            in_imm = W'($urandom_range(0, 255));
            in_reg = W'($urandom_range(0, 255));
            in_alu = W'($urandom_range(0, 255));
            rd_addr = AW'($urandom_range(0, 3));
            dump_req = 1'($urandom_range(0, 1));
            dump_addr = AW'($urandom_range(0, 3));
            out_ready = 1'($urandom_range(0, 1));
            cycle();
        end

        // asynchronous reset while the buffer is full
        set_op(2'd1, 2'd0, 2'd1); in_imm = 8'hA5;
        dump_req = 1'b1; dump_addr = 2'd1; out_ready = 1'b0;
        cycle();
        set_op(2'd0, 2'd0, 2'd0); dump_req = 1'b0;
        check("pre_reset_full", 32'(valid_o[0]), 32'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check("async_out_valid", 32'(valid_o[0]), 32'd0);
        check("async_out_reg", 32'(reg_o[1]), 32'd0);
        check("async_busy", 32'(busy_o[0]), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr = AW'(i);
            #1;
            check("async_entry", 32'(alu_o[0]), 32'd0);
            check("async_zero", 32'(zero_o[1]), 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        cycle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
